// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the branch predictor slice.
//  - bp_ctr_e   : 2-bit saturating counter encodings. The MSB is the prediction.
//  - bp_track_t : the prediction record that travels with an instruction
//                 from IF through ID to EX.
//  - sat_update : next value of a counter after one resolved branch.
// Optional feature macro used elsewhere in the slice: BP_STATS_EN.
// ---------------------------------------------------------------------------
package bp_pkg;

  // Default table index width. The table holds 2**BP_IDX_W counters.
  localparam int BP_IDX_W = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic                pred;
    logic [BP_IDX_W-1:0] idx;
  } bp_track_t;

  // Step towards ST when taken and towards SNT when not taken, holding at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Groups the fetch-side and EX-side signals of the branch predictor.
// The master is the pipeline / PC-unit side, and the slave is the predictor.
//  buble          stall, same as the PC register enable
//  if_pc          PC being fetched
//  if_is_branch   predecode: fetched instruction is a conditional branch
//  predict_taken  prediction towards the PC unit (MPC)
//  ex_is_branch   EX instruction is a conditional branch
//  ex_is_jalr     EX instruction is JALR
//  ex_taken       EX branch condition result
//  ex_alt_pc      not-chosen path carried with the EX instruction
//  ex_jalr_target computed JALR target
//  is_valid       0 = redirect this cycle
//  correct_pc     redirect address
//  stat_branches / stat_mispredicts exist only when BP_STATS_EN is defined.
// ---------------------------------------------------------------------------
interface branch_predictor_if #(parameter int size = 32);
  logic            buble;
  logic [size-1:0] if_pc;
  logic            if_is_branch;
  logic            predict_taken;
  logic            ex_is_branch;
  logic            ex_is_jalr;
  logic            ex_taken;
  logic [size-1:0] ex_alt_pc;
  logic [size-1:0] ex_jalr_target;
  logic            is_valid;
  logic [size-1:0] correct_pc;
`ifdef BP_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output buble, if_pc, if_is_branch, ex_is_branch, ex_is_jalr, ex_taken,
           ex_alt_pc, ex_jalr_target,
    input  predict_taken, is_valid, correct_pc
`ifdef BP_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  buble, if_pc, if_is_branch, ex_is_branch, ex_is_jalr, ex_taken,
           ex_alt_pc, ex_jalr_target,
    output predict_taken, is_valid, correct_pc
`ifdef BP_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/bp_counter_table.sv
// ---------------------------------------------------------------------------
// bp_counter_table
// Direct-mapped table of 2**IDX_W two-bit saturating counters.
// It has one asynchronous read port and one synchronous read-modify-write port.
// Reset sets every entry to WNT. A read and a write to the same index in one
// cycle return the value from before the write.
//  clk, reset  clock and synchronous active-high reset
//  i_raddr     read index;   o_rdata current counter value
//  i_we        write enable; i_waddr index to update; i_taken outcome
// ---------------------------------------------------------------------------
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [1:0]       o_rdata,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic             i_taken
);
  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] r_ctr [DEPTH];

  assign o_rdata = r_ctr[i_raddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= WNT;
      end
    end else if (i_we) begin
      r_ctr[i_waddr] <= sat_update(r_ctr[i_waddr], i_taken);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// This block predicts branch direction at fetch and resolves the prediction in EX.
// Each prediction record travels through ID and EX next to its instruction.
// In EX the record is compared with the real outcome. On a mispredict, or on
// any JALR, the block requests a redirect. The redirect is combinational and
// appears in the same cycle as the EX instruction.
//  clk    rising-edge clock
//  reset  synchronous, active-high
//  bus    branch_predictor_if.slave (see the interface for the signal list)
// Optional feature: when BP_STATS_EN is defined, the block adds the
// stat_branches and stat_mispredicts counters.
// The idx field of the tracking record is BP_IDX_W wide. If you override
// IDX_W, change BP_IDX_W in bp_pkg to the same value.
// ---------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int size  = 32,
  parameter int IDX_W = BP_IDX_W
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  logic [IDX_W-1:0] w_if_idx;
  logic [1:0]       w_rd_ctr;
  logic             w_predict;
  logic             w_jalr_redirect;
  logic             w_mispredict;
  logic             w_redirect;
  logic             w_resolve;
  logic             w_unused_pc_hi;
  bp_track_t        r_id_q;
  bp_track_t        r_ex_q;

  assign w_if_idx       = bus.if_pc[IDX_W-1:0];
  assign w_unused_pc_hi = ^bus.if_pc[size-1:IDX_W];

  bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .reset   (reset),
    .i_raddr (w_if_idx),
    .o_rdata (w_rd_ctr),
    .i_we    (w_resolve),
    .i_waddr (r_ex_q.idx),
    .i_taken (bus.ex_taken)
  );

  assign w_predict         = bus.if_is_branch & w_rd_ctr[1] & ~reset;
  assign bus.predict_taken = w_predict;

  // Gate on reset so that a stale EX record can neither redirect nor train
  // the table in the cycle when reset is asserted.
  assign w_resolve       = ~reset & r_ex_q.valid & bus.ex_is_branch;
  assign w_jalr_redirect = ~reset & r_ex_q.valid & bus.ex_is_jalr;
  assign w_mispredict    = w_resolve & (bus.ex_taken != r_ex_q.pred);
  assign w_redirect      = w_jalr_redirect | w_mispredict;

  assign bus.is_valid   = ~w_redirect;
  assign bus.correct_pc = w_jalr_redirect ? bus.ex_jalr_target :
                          w_mispredict    ? bus.ex_alt_pc      : '0;

  // Tracking pipe. A flush overrides the stall. A stall keeps ID and sends a
  // bubble into EX.
  always_ff @(posedge clk) begin
    if (reset || w_redirect) begin
      r_id_q <= '0;
      r_ex_q <= '0;
    end else if (bus.buble) begin
      r_ex_q <= '0;
    end else begin
      r_id_q <= '{valid: 1'b1, pred: w_predict, idx: w_if_idx};
      r_ex_q <= r_id_q;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_resolve)    r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign bus.stat_branches    = r_stat_branches;
  assign bus.stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor. Inputs change on the falling edge, and
// outputs are checked 1 time unit later. Expected values are worked out by hand
// from the counter and pipe behaviour.
// ---------------------------------------------------------------------------
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  branch_predictor_if #(.size(32)) bus ();

  branch_predictor #(.size(32), .IDX_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.buble          = 1'b0;
    bus.if_pc          = '0;
    bus.if_is_branch   = 1'b0;
    bus.ex_is_branch   = 1'b0;
    bus.ex_is_jalr     = 1'b0;
    bus.ex_taken       = 1'b0;
    bus.ex_alt_pc      = '0;
    bus.ex_jalr_target = '0;
  endtask

  task automatic fetch(input logic br, input logic [31:0] pc);
    bus.if_is_branch = br;
    bus.if_pc        = pc;
  endtask

  task automatic ex(input logic br, input logic tk, input logic [31:0] alt);
    bus.ex_is_branch = br;
    bus.ex_taken     = tk;
    bus.ex_alt_pc    = alt;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
`ifdef BP_STATS_EN
    chk({tag, "_branches"},    bus.stat_branches,    br);
    chk({tag, "_mispredicts"}, bus.stat_mispredicts, mp);
`else
    if (br == mp + 32'hFFFF_FFFF) $display("note: %s", tag);
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle();
    fetch(1'b1, 32'h05);
    @(negedge clk); #1;
    // Outputs while reset is held.
    chk("rst_predict", {31'd0, bus.predict_taken}, 32'd0);
    chk("rst_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk("rst_correct_pc", bus.correct_pc, 32'd0);
    cycle();
    // Every counter is WNT after reset.
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("rst_ctr%0d", i), {30'd0, dut.u_table.r_ctr[i]}, 32'd1);
    end
    reset = 1'b0;

    // Test 1 (A): fetch branch 0x05, counter WNT, so not taken.
    fetch(1'b1, 32'h05); #1;
    chk("A_predict", {31'd0, bus.predict_taken}, 32'd0);
    cycle();
    // B: non-branch fetch, EX empty.
    fetch(1'b0, 32'h06); #1;
    chk("B_is_valid", {31'd0, bus.is_valid}, 32'd1);
    cycle();
    // C: branch 0x05 is in EX. It was predicted 0 and is taken, so redirect to alt.
    fetch(1'b0, 32'h07); ex(1'b1, 1'b1, 32'h20); #1;
    chk("C_is_valid", {31'd0, bus.is_valid}, 32'd0);
    chk("C_correct_pc", bus.correct_pc, 32'h20);
    cycle();
    // D: the pipe was flushed, so the EX branch flags are ignored. ctr[5] is now WT.
    ex(1'b1, 1'b0, 32'h21); fetch(1'b1, 32'h05); #1;
    chk("D_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk("D_correct_pc", bus.correct_pc, 32'd0);
    chk("D_predict", {31'd0, bus.predict_taken}, 32'd1);
    chk("D_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd2);
    cycle();
    // E: the invalid EX slot in D must not have trained the table.
    ex(1'b0, 1'b0, 32'h0); fetch(1'b0, 32'h06); #1;
    chk("E_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd2);
    cycle();
    // F: branch predicted taken resolves taken, so no redirect.
    ex(1'b1, 1'b1, 32'h30); fetch(1'b0, 32'h07); #1;
    chk("F_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk("F_correct_pc", bus.correct_pc, 32'd0);
    cycle();
    // G: ctr[5] saturates at ST. Fetch 0x05 again.
    ex(1'b0, 1'b0, 32'h0); fetch(1'b1, 32'h05); #1;
    chk("G_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd3);
    chk("G_predict", {31'd0, bus.predict_taken}, 32'd1);
    cycle();
    // H: a non-branch at a strongly taken index still predicts 0.
    fetch(1'b0, 32'h05); #1;
    chk("H_nonbranch_predict", {31'd0, bus.predict_taken}, 32'd0);
    cycle();
    // Test 3 (I): predicted taken but not taken, so redirect to 0x06.
    ex(1'b1, 1'b0, 32'h06); fetch(1'b0, 32'h07); #1;
    chk("I_is_valid", {31'd0, bus.is_valid}, 32'd0);
    chk("I_correct_pc", bus.correct_pc, 32'h06);
    cycle();
    // J: after the flush, EX is invalid. ctr[5] is now WT. Stats are 3 branches, 2 mispredicts.
    fetch(1'b0, 32'h08); #1;
    chk("J_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk("J_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd2);
    chk_stats("J", 32'd3, 32'd2);
    cycle();
    // K: the instruction at 0x08 moves into EX on this edge.
    ex(1'b0, 1'b0, 32'h0); fetch(1'b0, 32'h11);
    cycle();
    // Test 4 (L): JALR in EX redirects to its target.
    bus.ex_is_jalr = 1'b1; bus.ex_jalr_target = 32'h40; #1;
    chk("L_is_valid", {31'd0, bus.is_valid}, 32'd0);
    chk("L_correct_pc", bus.correct_pc, 32'h40);
    cycle();
    // M: the JALR left the counters unchanged. Fetch branch 0x09 (WNT).
    bus.ex_is_jalr = 1'b0; bus.ex_jalr_target = '0; fetch(1'b1, 32'h09); #1;
    chk("M_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk("M_ctr8", {30'd0, dut.u_table.r_ctr[8]}, 32'd1);
    chk("M_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd2);
    chk("M_predict", {31'd0, bus.predict_taken}, 32'd0);
    chk_stats("M", 32'd3, 32'd2);
    cycle();
    // Test 5 (N): stall for one cycle with the branch at 0x09 held in ID.
    bus.buble = 1'b1; fetch(1'b0, 32'h0A);
    cycle();
    // O: EX holds the bubble, so the branch flags are ignored.
    bus.buble = 1'b0; ex(1'b1, 1'b1, 32'h50); #1;
    chk("O_bubble_is_valid", {31'd0, bus.is_valid}, 32'd1);
    cycle();
    // P: branch 0x09 arrives one cycle late with pred=0. It is taken, so redirect.
    fetch(1'b0, 32'h0B); #1;
    chk("P_is_valid", {31'd0, bus.is_valid}, 32'd0);
    chk("P_correct_pc", bus.correct_pc, 32'h50);
    cycle();
    // Test 6 (Q): fetch branch 0x0C (WNT).
    ex(1'b0, 1'b0, 32'h0); fetch(1'b1, 32'h0C); #1;
    chk("Q_predict", {31'd0, bus.predict_taken}, 32'd0);
    chk("Q_ctr9", {30'd0, dut.u_table.r_ctr[9]}, 32'd2);
    chk_stats("Q", 32'd4, 32'd3);
    cycle();
    // R: the branch at 0x0C moves into ID.
    fetch(1'b0, 32'h0D);
    cycle();
    // S: index 0x0C is resolved and fetched in the same cycle, so the pre-update value is used.
    ex(1'b1, 1'b1, 32'h60); fetch(1'b1, 32'h0C); #1;
    chk("S_same_idx_predict", {31'd0, bus.predict_taken}, 32'd0);
    chk("S_is_valid", {31'd0, bus.is_valid}, 32'd0);
    chk("S_correct_pc", bus.correct_pc, 32'h60);
    cycle();
    // T: the update is now visible.
    ex(1'b0, 1'b0, 32'h0); fetch(1'b1, 32'h0C); #1;
    chk("T_predict", {31'd0, bus.predict_taken}, 32'd1);
    cycle();
    // U: the branch at 0x0C (pred=1) moves into EX on this edge.
    fetch(1'b0, 32'h0D);
    cycle();
    // V: reset while a mispredict sits in EX. No redirect, and outputs are forced.
    reset = 1'b1; ex(1'b1, 1'b0, 32'h70); fetch(1'b1, 32'h05); #1;
    chk("V_rst_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk("V_rst_correct_pc", bus.correct_pc, 32'd0);
    chk("V_rst_predict", {31'd0, bus.predict_taken}, 32'd0);
    cycle();
    // W: after reset, the table is back to WNT and in-flight records are gone.
    reset = 1'b0; #1;
    chk("W_predict", {31'd0, bus.predict_taken}, 32'd0);
    chk("W_ctr12", {30'd0, dut.u_table.r_ctr[12]}, 32'd1);
    chk("W_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd1);
    chk("W_is_valid", {31'd0, bus.is_valid}, 32'd1);
    chk_stats("W", 32'd0, 32'd0);
    cycle();
    // X: with both stages empty, the EX flags from W must not have trained ctr[5].
    ex(1'b0, 1'b0, 32'h0); #1;
    chk("X_ctr5", {30'd0, dut.u_table.r_ctr[5]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
